// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU core.
// Imported by the cycle controller and its bench.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM        = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALTED     = 3'd6
  } cycle_state_t;

  localparam logic [1:0] PC_REL = 2'b00;
  localparam logic [1:0] PC_ABS = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mips_cycle_controller.sv
// Multi-cycle sequencer: fetch, exec, mem, writeback.
// Drives bus strobes, PC advance and halt detection.
module mips_cycle_controller
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        mem_waitrequest,
  input  logic        dec_branch,
  input  logic        dec_branch_taken,
  input  logic [1:0]  dec_pcsrc,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_regwrite,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_is_fetch,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic        CntEn,
  output logic        is_branch,
  output logic [1:0]  PCControl,
  output logic        active,
  output logic [2:0]  state
);

  cycle_state_t state_q, state_d;
  logic         br_q, br_d;
  logic [1:0]   pcsrc_q, pcsrc_d;
  logic         ld_q, ld_d;
  logic         st_q, st_d;
  logic         rw_q, rw_d;
  logic         delay_q, delay_d;
  logic         halt_hit;

  // The PC owns the reset vector; kept here only for reference.
  logic unused_rv;
  assign unused_rv = ^RESET_VECTOR;

  // Halt is held off while a branch delay slot is still owed.
  assign halt_hit = (pc == HALT_ADDR) && !delay_q;

  // Next-state logic; decode fields are captured in EXEC so
  // later states never look at the decoder combinationally.
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    pcsrc_d = pcsrc_q;
    ld_d    = ld_q;
    st_d    = st_q;
    rw_d    = rw_q;
    delay_d = delay_q;
    unique case (state_q)
      FETCH: begin
        if (halt_hit)
          state_d = HALTED;
        else if (!mem_waitrequest)
          state_d = EXEC;
        else
          state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (!mem_waitrequest)
          state_d = EXEC;
      end
      EXEC: begin
        br_d    = dec_branch & dec_branch_taken;
        pcsrc_d = dec_pcsrc;
        ld_d    = dec_load;
        st_d    = dec_store & ~dec_load;
        rw_d    = dec_regwrite;
        if (dec_load || dec_store)
          state_d = MEM;
        else
          state_d = WB;
      end
      MEM, MEM_WAIT: begin
        if (!mem_waitrequest)
          state_d = WB;
        else
          state_d = MEM_WAIT;
      end
      WB: begin
        delay_d = br_q;
        state_d = FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  // State and captured decode flags, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      br_q    <= 1'b0;
      pcsrc_q <= PC_REL;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      rw_q    <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      pcsrc_q <= pcsrc_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      rw_q    <= rw_d;
      delay_q <= delay_d;
    end
  end

  // Output decode; reset low masks every strobe in the same cycle.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    reg_write    = 1'b0;
    CntEn        = 1'b0;
    is_branch    = 1'b0;
    PCControl    = PC_REL;
    active       = 1'b1;
    if (rst) begin
      unique case (state_q)
        FETCH: begin
          if (halt_hit) begin
            active = 1'b0;
          end else begin
            mem_read     = 1'b1;
            mem_is_fetch = 1'b1;
            ir_write     = !mem_waitrequest;
          end
        end
        FETCH_WAIT: begin
          mem_read     = 1'b1;
          mem_is_fetch = 1'b1;
          ir_write     = !mem_waitrequest;
        end
        MEM, MEM_WAIT: begin
          mem_read  = ld_q;
          mem_write = st_q;
          mdr_write = ld_q & !mem_waitrequest;
        end
        WB: begin
          reg_write = rw_q;
          CntEn     = 1'b1;
          is_branch = br_q;
          PCControl = pcsrc_q;
        end
        HALTED: active = 1'b0;
        default: ;
      endcase
    end
  end

  assign state = rst ? state_q : FETCH;

endmodule

// File: doc/mips_cycle_controller.md
# mips_cycle_controller

Multi-cycle sequencer for the MIPS CPU core. It steps each instruction through fetch, execute, optional memory access and writeback over a shared memory bus with wait-states, and drives the program counter's advance strobe, branch flag and branch-source select. It also detects the halt condition and drives the CPU `active` output.

## Interface
Parameters:
- `HALT_ADDR`, `32'h0000_0000`: fetch address that halts the CPU.
- `RESET_VECTOR`, `32'hBFC0_0000`: documentation only; the PC owns the reset value.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `pc`  in  32  current PC value.
- `mem_waitrequest`  in  1  memory stall; the request must be held while it is high.
- `dec_branch`  in  1  decoded instruction is a branch or jump; valid in EXEC.
- `dec_branch_taken`  in  1  branch condition is true; valid in EXEC.
- `dec_pcsrc`  in  2  00 relative, 01 absolute target, 10 register; valid in EXEC.
- `dec_load`  in  1  decoded load; valid in EXEC.
- `dec_store`  in  1  decoded store; valid in EXEC.
- `dec_regwrite`  in  1  instruction writes the register file; valid in EXEC.
- `mem_read`  out  1  bus read request.
- `mem_write`  out  1  bus write request.
- `mem_is_fetch`  out  1  1 = the bus address is the PC, 0 = data address.
- `ir_write`  out  1  latch `readdata` into the instruction register.
- `mdr_write`  out  1  latch load data.
- `reg_write`  out  1  register-file write enable.
- `CntEn`  out  1  PC advance strobe, one cycle per instruction.
- `is_branch`  out  1  marks the advancing instruction as a taken branch.
- `PCControl`  out  2  branch address source.
- `active`  out  1  CPU running.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH, FETCH_WAIT, EXEC, MEM, MEM_WAIT, WB, HALTED.
- On reset, enter FETCH. All outputs are 0 except `active`, which is 1.
- **FETCH**
  - If `pc == HALT_ADDR` and no branch delay is pending: go to HALTED and drive `active` = 0.
  - Otherwise: assert `mem_read` and `mem_is_fetch`. If `mem_waitrequest` = 0, assert `ir_write` and go to EXEC; else go to FETCH_WAIT.
- **FETCH_WAIT**: hold `mem_read` and `mem_is_fetch`. When `mem_waitrequest` falls, assert `ir_write` and go to EXEC.
- **EXEC**
  - Register `dec_branch & dec_branch_taken` into `br_q` and `dec_pcsrc` into `pcsrc_q`.
  - Go to MEM if `dec_load` or `dec_store`; else go to WB.
- **MEM**: assert `mem_read` (load) or `mem_write` (store), with `mem_is_fetch` = 0.
  - If `mem_waitrequest` = 0: a load asserts `mdr_write`; go to WB.
  - Else go to MEM_WAIT, which holds the request with the same completion rule.
- **WB**: assert `reg_write` = `dec_regwrite`, `CntEn` = 1, `is_branch` = `br_q`, `PCControl` = `pcsrc_q`; go to FETCH.
- **Branch delay**: the PC fetches the delay slot and only then jumps. The controller sets `delay_pending` when `is_branch` is issued and clears it at the next `CntEn`. The halt check is suppressed while `delay_pending` = 1, so a `jr` to 0 still executes its delay slot before halting.
- **HALTED**: absorbing; all strobes are 0. Only reset leaves it.
- **Reset mid-operation**: reset wins in any state, including during a wait. Drop bus requests in the same cycle and clear `delay_pending`.
- A simultaneous decode of load and store is illegal; treat it as a load.

## Timing
- All outputs are combinational from state plus registered flags. No output depends combinationally on `dec_*` in WB.
- Minimum instruction cycles: 3 (FETCH, EXEC, WB) for ALU and branch; 4 for load/store. Each wait cycle adds 1.
- `CntEn` is high for exactly 1 cycle per retired instruction. The PC updates on the edge that ends WB, and the new `pc` is visible in the following FETCH.
- `mem_read` and `mem_write` are never both high. Requests stay stable while `mem_waitrequest` = 1.
- `active` falls in the cycle of HALTED entry, i.e. the first FETCH cycle where the halt condition holds.

## Structure
- Shared package `mips_cpu_pkg`: state enum `cycle_state_t` (3 bits), PCControl encodings `PC_REL` = 2'b00, `PC_ABS` = 2'b01, `PC_REG` = 2'b10, and the `HALT_ADDR` default.
- Single module with no sub-modules. The FSM next-state logic, output decode and the `br_q`/`pcsrc_q`/`delay_pending` registers total about 150–200 lines.

## Test plan
- Reset with `rst` = 0 for 2 cycles, then ALU op with no waits → states FETCH, EXEC, WB; `CntEn` high only in cycle 3; `active` = 1 throughout.
- Load with `mem_waitrequest` high for 2 cycles in the fetch and 1 in MEM → 7 cycles total; `mem_read` held stable; `mdr_write` pulses once; `reg_write` in WB.
- Taken `beq` with `dec_pcsrc` = 00 → WB drives `is_branch` = 1 and `PCControl` = 00. The next instruction (delay slot) retires with `is_branch` = 0.
- `jr` to 0 (`dec_pcsrc` = 10): `pc` becomes 0 while the delay slot is pending → the delay slot still fetches. At the next FETCH with `pc` = 0, HALTED is entered and `active` = 0; no further bus requests.
- Assert `rst` = 0 during MEM_WAIT of a store → next cycle state = FETCH; `mem_write` = 0 in the reset cycle; `delay_pending` cleared.
- Store → `mem_write` = 1 with `mem_is_fetch` = 0 in MEM; `reg_write` = 0 in WB; `mem_read` is never high at the same time as `mem_write`.
